mf_pll_lock_sequencer: RTL and testbench
========================================

// Module: mf_pll_lock_sequencer
// PURPOSE
//  Sequences the core PLL (3 outputs: video/system/phase-shifted pixel clocks) out of reset.
//  Holds the PLL in reset, waits for lock, requires lock to stay stable, then releases core reset.
//  Detects loss of lock and re-runs the sequence. Sits in the clk_74a domain beside the PLL wrapper.
// PARAMETERS
//  RST_CYCLES     16      cycles pll_rst is held high per attempt (>=2)
//  LOCK_TIMEOUT   74250   cycles to wait for lock before retrying (1 ms @ 74.25 MHz)
//  STABLE_CYCLES  1024    consecutive synchronized-lock cycles required before release (>=1)
//  MAX_RETRIES    8       failed-attempt limit (used only with PLL_RETRY_LIMIT_EN)
//  CNT_W          20      shared cycle-counter width; must hold max of the three cycle params
// PORTS
//  clk_74a     in   1  74.25 MHz reference clock; all logic on rising edge
//  reset_n     in   1  synchronous active-low reset
//  restart     in   1  single-cycle request to re-run the sequence (e.g. after clock change)
//  pll_locked  in   1  PLL locked, asynchronous to clk_74a
//  pll_rst     out  1  PLL reset, active high
//  sys_reset_n out  1  core reset, active low, released only in RUN
//  pll_ready   out  1  high while in RUN
//  lock_lost   out  1  sticky: lock dropped while in RUN
//  retry_cnt   out  8  failed attempts (timeouts + lock losses), saturates at 255
//  pll_fail    out  1  retry limit reached (see CONFIGURATION)
// BEHAVIOUR
//  - pll_locked passes a 2-flop synchronizer (reset 0) -> lock_s. No other use of raw input.
//  - Reset (reset_n=0 at edge): state=RST, cnt=0, pll_rst=1, sys_reset_n=0, pll_ready=0,
//    lock_lost=0, retry_cnt=0, pll_fail=0, synchronizer=0. All outputs registered.
//  - States: RST, WAIT, STABLE, RUN, FAIL (FAIL only with macro).
//  - RST: pll_rst=1; cnt counts 0..RST_CYCLES-1, then -> WAIT, cnt=0. pll_rst=0 from WAIT on.
//  - WAIT: lock_s=1 -> STABLE, cnt=0. Else cnt==LOCK_TIMEOUT-1 -> RST, retry_cnt+1.
//  - STABLE: lock_s=0 -> WAIT, cnt=0 (glitch restarts timeout; not a retry).
//    cnt==STABLE_CYCLES-1 with lock_s=1 -> RUN; sys_reset_n=1, pll_ready=1 on that edge.
//  - RUN: lock_s=0 -> RST on next edge; same edge sys_reset_n=0, pll_ready=0, pll_rst=1,
//    lock_lost=1, retry_cnt+1.
//  - Latency: pll_locked rise (held) -> sys_reset_n rise = 2 sync + STABLE_CYCLES edges.
//  - restart=1 in any state: -> RST, cnt=0, outputs as in RST; retry_cnt unchanged;
//    lock_lost cleared. restart has priority over timeout/lock events in same cycle.
//  - retry_cnt saturates at 8'hFF (no wrap). cnt never exceeds its terminal value.
//  - reset_n overrides restart and everything else.
// CONFIGURATION
//  PLL_RETRY_LIMIT_EN defined:
//   - A retry_cnt increment that makes retry_cnt==MAX_RETRIES goes to FAIL instead of RST.
//   - FAIL: pll_rst=1, sys_reset_n=0, pll_ready=0, pll_fail=1; lock_s ignored.
//   - Leave FAIL only by reset_n or restart; restart here also clears retry_cnt and pll_fail.
//  PLL_RETRY_LIMIT_EN undefined:
//   - Unlimited retries, FAIL state absent, pll_fail tied 0, MAX_RETRIES ignored,
//     restart never clears retry_cnt.
// TESTING  (RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, MAX_RETRIES=3)
//  1 reset_n low 3 cycles then high, pll_locked high 20 cycles later -> pll_rst high exactly
//    4 cycles after reset release; sys_reset_n rises 10 edges after pll_locked rise; retry_cnt=0.
//  2 pll_locked never high -> pll_rst re-pulses every 104 cycles; retry_cnt 1,2,3...;
//    with macro: pll_fail=1 after 3rd timeout, pll_rst stays 1; without: keeps retrying.
//  3 In RUN drop pll_locked 1 cycle -> sys_reset_n low 3 edges later, lock_lost=1,
//    retry_cnt+1, pll_rst high 4 cycles, full sequence repeats.
//  4 In STABLE drop pll_locked 1 cycle at cnt=5 -> back to WAIT, no retry increment,
//    release delayed by full 8 stable cycles after lock returns.
//  5 restart pulse in RUN, same cycle as lock drop -> RST entered, retry_cnt unchanged,
//    lock_lost=0; with macro, restart in FAIL clears retry_cnt and pll_fail.
//  6 retry_cnt forced to 255 via repeated timeouts (no macro) -> stays 255, no wrap.

Source files
------------

// File: rtl/mf_pll_lock_sequencer.sv
// PLL out-of-reset sequencer: pulse pll_rst, wait for synchronized lock, require it stable, release core reset.
// Define PLL_RETRY_LIMIT_EN to park in a FAIL state once MAX_RETRIES failed attempts have accumulated.
module mf_pll_lock_sequencer #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 74250,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES   = 8,
   parameter int CNT_W         = 20
) (
   input  logic       clk_74a,
   input  logic       reset_n,
   input  logic       restart,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_reset_n,
   output logic       pll_ready,
   output logic       lock_lost,
   output logic [7:0] retry_cnt,
   output logic       pll_fail
);

   typedef enum logic [2:0] {
      S_RST,
      S_WAIT,
      S_STABLE,
      S_RUN
`ifdef PLL_RETRY_LIMIT_EN
      , S_FAIL
`endif
   } state_t;

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   if (RST_CYCLES < 2 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1 ||
       MAX_RETRIES < 1 || MAX_RETRIES > 255 ||
       ((RST_CYCLES - 1) >> CNT_W) != 0 || ((LOCK_TIMEOUT - 1) >> CNT_W) != 0 ||
       ((STABLE_CYCLES - 1) >> CNT_W) != 0) begin : g_bad_params
      $error("mf_pll_lock_sequencer: illegal parameter combination");
   end

   state_t           state;
   state_t           retry_next_state;
   logic [CNT_W-1:0] cnt;
   logic             sync1;
   logic             lock_s;
   logic [7:0]       retry_inc;

   assign retry_inc = (retry_cnt == 8'hFF) ? retry_cnt : retry_cnt + 8'd1;

`ifdef PLL_RETRY_LIMIT_EN
   localparam logic [7:0] RETRY_MAX = 8'(MAX_RETRIES);
   logic retry_limit_hit;
   assign retry_limit_hit  = (retry_inc == RETRY_MAX);
   assign retry_next_state = retry_limit_hit ? S_FAIL : S_RST;
`else
   assign retry_next_state = S_RST;
   assign pll_fail         = 1'b0;
`endif

   // The WAIT cycle that first sees lock_s counts as the first of the STABLE_CYCLES
   // consecutive lock cycles, so STABLE is entered with cnt already at 1.
   always_ff @(posedge clk_74a) begin
      if (!reset_n) begin
         sync1       <= 1'b0;
         lock_s      <= 1'b0;
         state       <= S_RST;
         cnt         <= '0;
         pll_rst     <= 1'b1;
         sys_reset_n <= 1'b0;
         pll_ready   <= 1'b0;
         lock_lost   <= 1'b0;
         retry_cnt   <= 8'd0;
`ifdef PLL_RETRY_LIMIT_EN
         pll_fail    <= 1'b0;
`endif
      end else begin
         sync1  <= pll_locked;
         lock_s <= sync1;
         if (restart) begin
            state       <= S_RST;
            cnt         <= '0;
            pll_rst     <= 1'b1;
            sys_reset_n <= 1'b0;
            pll_ready   <= 1'b0;
            lock_lost   <= 1'b0;
`ifdef PLL_RETRY_LIMIT_EN
            if (state == S_FAIL) begin
               retry_cnt <= 8'd0;
               pll_fail  <= 1'b0;
            end
`endif
         end else begin
            case (state)
               S_RST: begin
                  if (cnt == RST_LAST) begin
                     state   <= S_WAIT;
                     cnt     <= '0;
                     pll_rst <= 1'b0;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
               S_WAIT: begin
                  if (lock_s) begin
                     if (STABLE_CYCLES == 1) begin
                        state       <= S_RUN;
                        cnt         <= '0;
                        sys_reset_n <= 1'b1;
                        pll_ready   <= 1'b1;
                     end else begin
                        state <= S_STABLE;
                        cnt   <= CNT_ONE;
                     end
                  end else if (cnt == TIMEOUT_LAST) begin
                     state     <= retry_next_state;
                     cnt       <= '0;
                     pll_rst   <= 1'b1;
                     retry_cnt <= retry_inc;
`ifdef PLL_RETRY_LIMIT_EN
                     pll_fail  <= retry_limit_hit;
`endif
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
               S_STABLE: begin
                  if (!lock_s) begin
                     state <= S_WAIT;
                     cnt   <= '0;
                  end else if (cnt == STABLE_LAST) begin
                     state       <= S_RUN;
                     cnt         <= '0;
                     sys_reset_n <= 1'b1;
                     pll_ready   <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
               S_RUN: begin
                  if (!lock_s) begin
                     state       <= retry_next_state;
                     cnt         <= '0;
                     pll_rst     <= 1'b1;
                     sys_reset_n <= 1'b0;
                     pll_ready   <= 1'b0;
                     lock_lost   <= 1'b1;
                     retry_cnt   <= retry_inc;
`ifdef PLL_RETRY_LIMIT_EN
                     pll_fail    <= retry_limit_hit;
`endif
                  end
               end
`ifdef PLL_RETRY_LIMIT_EN
               S_FAIL: begin
                  cnt         <= '0;
                  pll_rst     <= 1'b1;
                  sys_reset_n <= 1'b0;
                  pll_ready   <= 1'b0;
                  pll_fail    <= 1'b1;
               end
`endif
               default: begin
                  state       <= S_RST;
                  cnt         <= '0;
                  pll_rst     <= 1'b1;
                  sys_reset_n <= 1'b0;
                  pll_ready   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mf_pll_lock_sequencer.sv
// Directed bench for mf_pll_lock_sequencer with small cycle parameters.
// Observed tuple: {pll_rst, sys_reset_n, pll_ready, lock_lost, pll_fail, retry_cnt}.
module tb_mf_pll_lock_sequencer;

   localparam int RST_CYCLES    = 4;
   localparam int LOCK_TIMEOUT  = 100;
   localparam int STABLE_CYCLES = 8;
   localparam int MAX_RETRIES   = 3;
   localparam int CNT_W         = 20;
   localparam int PERIOD        = RST_CYCLES + LOCK_TIMEOUT;
`ifdef PLL_RETRY_LIMIT_EN
   localparam bit LIMIT_EN = 1'b1;
`else
   localparam bit LIMIT_EN = 1'b0;
`endif

   logic       clk_74a = 1'b0;
   logic       reset_n;
   logic       restart;
   logic       pll_locked;
   logic       pll_rst;
   logic       sys_reset_n;
   logic       pll_ready;
   logic       lock_lost;
   logic [7:0] retry_cnt;
   logic       pll_fail;
   logic [12:0] obs;

   int vectors     = 0;
   int miscompares = 0;

   assign obs = {pll_rst, sys_reset_n, pll_ready, lock_lost, pll_fail, retry_cnt};

   always #5 clk_74a = ~clk_74a;

   mf_pll_lock_sequencer #(
      .RST_CYCLES   (RST_CYCLES),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .STABLE_CYCLES(STABLE_CYCLES),
      .MAX_RETRIES  (MAX_RETRIES),
      .CNT_W        (CNT_W)
   ) dut (
      .clk_74a    (clk_74a),
      .reset_n    (reset_n),
      .restart    (restart),
      .pll_locked (pll_locked),
      .pll_rst    (pll_rst),
      .sys_reset_n(sys_reset_n),
      .pll_ready  (pll_ready),
      .lock_lost  (lock_lost),
      .retry_cnt  (retry_cnt),
      .pll_fail   (pll_fail)
   );

   // Inputs change and outputs are sampled on the falling edge, half a period from the active edge.
   task automatic tick();
      @(negedge clk_74a);
   endtask

   task automatic test_reset();
      logic [12:0] exp;
      reset_n    = 1'b0;
      restart    = 1'b1;
      pll_locked = 1'b0;
      repeat (3) tick();
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL reset_state: got %h expected %h", obs, exp);
      end
      restart = 1'b0;
      reset_n = 1'b1;
   endtask

   task automatic test_startup();
      logic [12:0] exp;
      repeat (3) tick();
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL startup_rst_held: got %h expected %h", obs, exp);
      end
      tick();
      exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL startup_rst_dropped: got %h expected %h", obs, exp);
      end
      repeat (16) tick();
      pll_locked = 1'b1;
      repeat (9) tick();
      exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL startup_before_release: got %h expected %h", obs, exp);
      end
      tick();
      exp = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL startup_release: got %h expected %h", obs, exp);
      end
   endtask

   task automatic test_lock_loss();
      logic [12:0] exp;
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      tick();
      exp = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL loss_not_yet_seen: got %h expected %h", obs, exp);
      end
      tick();
      exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL loss_detected: got %h expected %h", obs, exp);
      end
      repeat (3) tick();
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL loss_rst_held: got %h expected %h", obs, exp);
      end
      tick();
      exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL loss_rst_dropped: got %h expected %h", obs, exp);
      end
      repeat (7) tick();
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL loss_before_rerelease: got %h expected %h", obs, exp);
      end
      tick();
      exp = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL loss_rerelease: got %h expected %h", obs, exp);
      end
   endtask

   task automatic test_restart_priority();
      logic [12:0] exp;
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      tick();
      restart = 1'b1;
      tick();
      restart = 1'b0;
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL restart_beats_loss: got %h expected %h", obs, exp);
      end
      repeat (4) tick();
      exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL restart_rst_dropped: got %h expected %h", obs, exp);
      end
      repeat (8) tick();
      exp = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL restart_rerelease: got %h expected %h", obs, exp);
      end
   endtask

   task automatic test_stable_glitch();
      logic [12:0] exp;
      restart = 1'b1;
      tick();
      restart = 1'b0;
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL glitch_restart: got %h expected %h", obs, exp);
      end
      repeat (7) tick();
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      repeat (4) tick();
      exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL glitch_no_early_release: got %h expected %h", obs, exp);
      end
      repeat (5) tick();
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL glitch_full_restable: got %h expected %h", obs, exp);
      end
      tick();
      exp = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL glitch_release: got %h expected %h", obs, exp);
      end
   endtask

   // Without lock the sequence repeats every PERIOD cycles; each timeout adds one retry.
   task automatic test_timeouts();
      logic [12:0] exp;
      int n;
      int exp_retry;
      bit exp_fail;
      bit exp_rst;
      int tmax;
      pll_locked = 1'b0;
      reset_n    = 1'b0;
      tick();
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL midrun_reset: got %h expected %h", obs, exp);
      end
      reset_n = 1'b1;
      tmax = LIMIT_EN ? 330 : 26630;
      for (int t = 1; t <= tmax; t++) begin
         tick();
         if (t <= 320 || t >= 26500) begin
            n         = t / PERIOD;
            exp_fail  = LIMIT_EN && (n >= MAX_RETRIES);
            exp_retry = LIMIT_EN ? ((n >= MAX_RETRIES) ? MAX_RETRIES : n) : ((n >= 255) ? 255 : n);
            exp_rst   = exp_fail ? 1'b1 : ((t % PERIOD) < RST_CYCLES);
            exp       = {exp_rst, 1'b0, 1'b0, 1'b0, exp_fail, 8'(exp_retry)};
            vectors++;
            if (obs !== exp) begin
               miscompares++;
               $display("[TB] FAIL timeout_cycle_%0d: got %h expected %h", t, obs, exp);
            end
         end
      end
   endtask

`ifdef PLL_RETRY_LIMIT_EN
   task automatic test_fail_restart();
      logic [12:0] exp;
      pll_locked = 1'b1;
      repeat (20) tick();
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL fail_ignores_lock: got %h expected %h", obs, exp);
      end
      restart = 1'b1;
      tick();
      restart = 1'b0;
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL fail_restart_clears: got %h expected %h", obs, exp);
      end
      repeat (12) tick();
      exp = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL fail_recovers: got %h expected %h", obs, exp);
      end
   endtask
`else
   task automatic test_saturated_restart();
      logic [12:0] exp;
      restart = 1'b1;
      tick();
      restart = 1'b0;
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd255};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL restart_keeps_retry: got %h expected %h", obs, exp);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_startup();
      test_lock_loss();
      test_restart_priority();
      test_stable_glitch();
      test_timeouts();
`ifdef PLL_RETRY_LIMIT_EN
      test_fail_restart();
`else
      test_saturated_restart();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
